// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter that turns whole read/write transactions from two requesters
// into atomic two-command sequences on a single-port RAM command interface.
module ram_cmd_arbiter #(
   parameter  int ADDR_SIZE  = 8,
   parameter  int DATA_WIDTH = 8,
   localparam int FIELD_W    = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH,
   localparam int CMD_W      = 2 + FIELD_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // requester A
   input  logic                  a_req_valid,
   output logic                  a_req_ready,
   input  logic                  a_req_we,
   input  logic [ADDR_SIZE-1:0]  a_req_addr,
   input  logic [DATA_WIDTH-1:0] a_req_wdata,
   output logic                  a_rsp_valid,
   output logic [DATA_WIDTH-1:0] a_rsp_rdata,
   output logic                  a_rsp_err,
   // requester B
   input  logic                  b_req_valid,
   output logic                  b_req_ready,
   input  logic                  b_req_we,
   input  logic [ADDR_SIZE-1:0]  b_req_addr,
   input  logic [DATA_WIDTH-1:0] b_req_wdata,
   output logic                  b_rsp_valid,
   output logic [DATA_WIDTH-1:0] b_rsp_rdata,
   output logic                  b_rsp_err,
   // RAM command interface
   output logic [CMD_W-1:0]      ram_din,
   output logic                  ram_rx_valid,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   input  logic                  ram_tx_valid,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RD_WAIT} state_t;
   typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_t;

   localparam logic [1:0] OP_SET_WADDR = 2'b00;
   localparam logic [1:0] OP_WRITE     = 2'b01;
   localparam logic [1:0] OP_SET_RADDR = 2'b10;
   localparam logic [1:0] OP_READ      = 2'b11;

   state_t                state_q, state_d;
   req_t                  last_grant_q, last_grant_d;
   req_t                  owner_q, owner_d;
   logic                  we_q, we_d;
   logic [ADDR_SIZE-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  a_rsp_valid_q, a_rsp_valid_d;
   logic [DATA_WIDTH-1:0] a_rsp_rdata_q, a_rsp_rdata_d;
   logic                  a_rsp_err_q, a_rsp_err_d;
   logic                  b_rsp_valid_q, b_rsp_valid_d;
   logic [DATA_WIDTH-1:0] b_rsp_rdata_q, b_rsp_rdata_d;
   logic                  b_rsp_err_q, b_rsp_err_d;

   logic                  grant_a, grant_b;
   logic [FIELD_W-1:0]    addr_field, data_field;

   // Zero-extend address and data into the shared command payload field.
   always_comb begin
      addr_field                 = '0;
      addr_field[ADDR_SIZE-1:0]  = addr_q;
      data_field                 = '0;
      data_field[DATA_WIDTH-1:0] = wdata_q;
   end

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      owner_d       = owner_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      a_rsp_valid_d = 1'b0;
      a_rsp_rdata_d = a_rsp_rdata_q;
      a_rsp_err_d   = a_rsp_err_q;
      b_rsp_valid_d = 1'b0;
      b_rsp_rdata_d = b_rsp_rdata_q;
      b_rsp_err_d   = b_rsp_err_q;
      grant_a       = 1'b0;
      grant_b       = 1'b0;
      ram_rx_valid  = 1'b0;
      ram_din       = '0;

      case (state_q)
         IDLE: begin
            // On a tie the requester that did not win last time goes first.
            if (a_req_valid && (!b_req_valid || last_grant_q == REQ_B)) begin
               grant_a = 1'b1;
            end else if (b_req_valid) begin
               grant_b = 1'b1;
            end
            if (grant_a || grant_b) begin
               owner_d      = grant_a ? REQ_A : REQ_B;
               last_grant_d = grant_a ? REQ_A : REQ_B;
               we_d         = grant_a ? a_req_we    : b_req_we;
               addr_d       = grant_a ? a_req_addr  : b_req_addr;
               wdata_d      = grant_a ? a_req_wdata : b_req_wdata;
               state_d      = ADDR;
            end
         end

         ADDR: begin
            ram_rx_valid = 1'b1;
            ram_din      = {we_q ? OP_SET_WADDR : OP_SET_RADDR, addr_field};
            state_d      = DATA;
         end

         DATA: begin
            ram_rx_valid = 1'b1;
            ram_din      = {we_q ? OP_WRITE : OP_READ, we_q ? data_field : {FIELD_W{1'b0}}};
            if (we_q) begin
               if (owner_q == REQ_A) begin
                  a_rsp_valid_d = 1'b1;
                  a_rsp_err_d   = 1'b0;
               end else begin
                  b_rsp_valid_d = 1'b1;
                  b_rsp_err_d   = 1'b0;
               end
               state_d = IDLE;
            end else begin
               state_d = RD_WAIT;
            end
         end

         RD_WAIT: begin
            // tx_valid may still be high from an earlier read, so capture on
            // fixed latency rather than waiting for an edge.
            if (owner_q == REQ_A) begin
               a_rsp_valid_d = 1'b1;
               a_rsp_rdata_d = ram_dout;
               a_rsp_err_d   = ~ram_tx_valid;
            end else begin
               b_rsp_valid_d = 1'b1;
               b_rsp_rdata_d = ram_dout;
               b_rsp_err_d   = ~ram_tx_valid;
            end
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   // NOTE: the latched transaction is reset along with the control state so a
   // dropped transaction leaves nothing stale behind after a mid-flight reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         last_grant_q  <= REQ_B;
         owner_q       <= REQ_A;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         a_rsp_valid_q <= 1'b0;
         a_rsp_rdata_q <= '0;
         a_rsp_err_q   <= 1'b0;
         b_rsp_valid_q <= 1'b0;
         b_rsp_rdata_q <= '0;
         b_rsp_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         owner_q       <= owner_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         a_rsp_valid_q <= a_rsp_valid_d;
         a_rsp_rdata_q <= a_rsp_rdata_d;
         a_rsp_err_q   <= a_rsp_err_d;
         b_rsp_valid_q <= b_rsp_valid_d;
         b_rsp_rdata_q <= b_rsp_rdata_d;
         b_rsp_err_q   <= b_rsp_err_d;
      end
   end

   // Grants exist only in IDLE; ready is additionally masked while in reset.
   assign a_req_ready = grant_a & rst_n;
   assign b_req_ready = grant_b & rst_n;

   assign a_rsp_valid = a_rsp_valid_q;
   assign a_rsp_rdata = a_rsp_rdata_q;
   assign a_rsp_err   = a_rsp_err_q;
   assign b_rsp_valid = b_rsp_valid_q;
   assign b_rsp_rdata = b_rsp_rdata_q;
   assign b_rsp_err   = b_rsp_err_q;
   assign busy        = (state_q != IDLE);

endmodule
